// File: rtl/mod_counter.sv
// Parametrised modulo counter: programmable terminal value, up/down, load/clear,
// wrap or saturate at the boundary, registered terminal-count pulse and sticky overflow.
module mod_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_load;
  logic             boundary;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    q_step   = q;
    boundary = 1'b0;
    if (up) begin
      if (q < limit) begin
        q_step = q + 1'b1;
      end else begin
        boundary = 1'b1;
        q_step   = SATURATE ? limit : '0;
      end
    end else begin
      if (q == '0) begin
        boundary = 1'b1;
        q_step   = SATURATE ? '0 : limit;
      end else if (q > limit) begin
        // Limit was lowered beneath the count: snap to it without a boundary event.
        q_step = limit;
      end else begin
        q_step = q - 1'b1;
      end
    end
  end

  assign q_load = (din > limit) ? limit : din;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= RST_Q;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      q  <= q_load;
      tc <= 1'b0;
    end else if (en) begin
      q  <= q_step;
      tc <= boundary;
      if (boundary) ovf <= 1'b1;
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: a vector table for the wrap instance plus
// hand-written sequences for saturate mode and a non-zero reset value.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset, clr, load, en, up;
  logic [7:0] din, limit;
  logic [7:0] q_w, q_s, q_r;
  logic       tc_w, tc_s, tc_r, ovf_w, ovf_s, ovf_r;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(0)) u_wrap (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .din(din), .en(en),
    .up(up), .limit(limit), .q(q_w), .tc(tc_w), .ovf(ovf_w));

  mod_counter #(.WIDTH(8), .SATURATE(1'b1), .RESET_VAL(0)) u_sat (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .din(din), .en(en),
    .up(up), .limit(limit), .q(q_s), .tc(tc_s), .ovf(ovf_s));

  mod_counter #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(250)) u_rv (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .din(din), .en(en),
    .up(up), .limit(limit), .q(q_r), .tc(tc_r), .ovf(ovf_r));

  typedef struct {
    logic       clr, load, en, up;
    logic [7:0] din, limit;
    logic [7:0] q;
    logic       tc, ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic c, logic l, logic e, logic u, logic [7:0] d,
                             logic [7:0] lim, logic [7:0] eq, logic et, logic eo);
    vec_t r;
    r.clr = c; r.load = l; r.en = e; r.up = u; r.din = d; r.limit = lim;
    r.q = eq; r.tc = et; r.ovf = eo;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic c, input logic l, input logic e,
                      input logic u, input logic [7:0] d, input logic [7:0] lim);
    reset = r; clr = c; load = l; en = e; up = u; din = d; limit = lim;
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string name, input logic [7:0] aq, input logic at, input logic ao,
                      input logic [7:0] eq, input logic et, input logic eo);
    check({name, ".q"},   32'(aq), 32'(eq));
    check({name, ".tc"},  32'(at), 32'(et));
    check({name, ".ovf"}, 32'(ao), 32'(eo));
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; din = '0; limit = '0;

    //            clr load en up  din   lim   q    tc ovf
    for (int i = 1; i <= 9; i++) tbl.push_back(v(0, 0, 1, 1, 0, 9, 8'(i), 0, 0));
    tbl.push_back(v(0, 0, 1, 1,   0,   9,   0, 1, 1));  // wrap 9 -> 0
    tbl.push_back(v(0, 0, 1, 1,   0,   9,   1, 0, 1));
    tbl.push_back(v(0, 0, 0, 1,   0,   9,   1, 0, 1));  // idle holds
    tbl.push_back(v(0, 1, 0, 1, 200, 100, 100, 0, 1));  // load clamps to limit
    tbl.push_back(v(1, 1, 0, 1,  50, 100,   0, 0, 0));  // clr beats load
    tbl.push_back(v(0, 0, 1, 1,   0,   0,   0, 1, 1));  // limit=0, en 1,0,1
    tbl.push_back(v(0, 0, 0, 1,   0,   0,   0, 0, 1));
    tbl.push_back(v(0, 0, 1, 0,   0,   0,   0, 1, 1));
    tbl.push_back(v(1, 0, 0, 1,   0,   0,   0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1,  40,  50,  40, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,  30,  30, 0, 0));  // limit lowered: snap, no tc
    tbl.push_back(v(0, 0, 1, 0,   0,  30,  29, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,  30,  28, 0, 0));
    tbl.push_back(v(0, 1, 0, 1,  40,  50,  40, 0, 0));
    tbl.push_back(v(0, 0, 1, 1,   0,  30,   0, 1, 1));  // q above limit counting up wraps
    tbl.push_back(v(1, 0, 0, 1,   0,  30,   0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,   0,   7,   7, 1, 1));  // down wrap 0 -> limit
    tbl.push_back(v(0, 0, 1, 0,   0,   7,   6, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,   0,   7,   6, 0, 1));

    // Reset state of all three instances.
    step(1, 0, 0, 0, 1, 0, 9);
    chk3("rst_wrap", q_w, tc_w, ovf_w, 8'd0, 1'b0, 1'b0);
    chk3("rst_sat",  q_s, tc_s, ovf_s, 8'd0, 1'b0, 1'b0);
    chk3("rst_rv",   q_r, tc_r, ovf_r, 8'd250, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      step(0, tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].din, tbl[i].limit);
      chk3($sformatf("vec%0d", i), q_w, tc_w, ovf_w, tbl[i].q, tbl[i].tc, tbl[i].ovf);
    end

    // Saturate, counting down: load 2, then four enables hold at 0.
    step(1, 0, 0, 0, 0, 0, 5);
    step(0, 0, 1, 0, 0, 2, 5);
    chk3("sat_load", q_s, tc_s, ovf_s, 8'd2, 1'b0, 1'b0);
    begin
      logic [7:0] eq[4]  = '{8'd1, 8'd0, 8'd0, 8'd0};
      logic       etc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic       eov[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
        step(0, 0, 0, 1, 0, 0, 5);
        chk3($sformatf("sat_dn%0d", i), q_s, tc_s, ovf_s, eq[i], etc[i], eov[i]);
      end
    end
    step(0, 1, 0, 0, 0, 0, 5);
    chk3("sat_clr", q_s, tc_s, ovf_s, 8'd0, 1'b0, 1'b0);

    // Saturate, counting up to limit=3 and holding there with tc high.
    begin
      logic [7:0] eq[5]  = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
      logic       etc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
        step(0, 0, 0, 1, 1, 0, 3);
        chk3($sformatf("sat_up%0d", i), q_s, tc_s, ovf_s, eq[i], etc[i], i >= 3);
      end
    end

    // RESET_VAL=250 at full-range limit: 251..255, wrap to 0, then reset wins over load/en.
    step(1, 0, 0, 0, 1, 0, 255);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_q;
      exp_q = 8'(251 + i);
      step(0, 0, 0, 1, 1, 0, 255);
      chk3($sformatf("rv_up%0d", i), q_r, tc_r, ovf_r, exp_q, i == 5, i >= 5);
    end
    step(1, 0, 1, 1, 1, 77, 255);
    chk3("rv_reset_load", q_r, tc_r, ovf_r, 8'd250, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
